min_hr_cntr: RTL and testbench
==============================

# min_hr_cntr

Minute/hour timekeeping stage fed directly by the seconds counter: consumes its one-cycle `f_1min` pulse on the same `clk_1sec` domain, maintains minutes (0–59) and hours (0–23), and presents BCD digits to the display driver. Includes a three-state set-time FSM driven by two debounced push-buttons, and emits `f_1hr`/`f_1day` carry flags for downstream date/alarm logic.

## Interface
- Parameters: none (limits come from the shared package).
- `clk_1sec`  in  1  1 Hz clock shared with the seconds counter
- `reset_n`  in  1  asynchronous, active-low reset
- `f_1min`  in  1  high for exactly one `clk_1sec` cycle while seconds == 59
- `mode_btn`  in  1  debounced, synchronous level; rising edge advances set mode
- `inc_btn`  in  1  debounced, synchronous level; rising edge increments selected field
- `min_bcd`  out  8  minutes, two BCD digits {tens, ones}
- `hr_bcd`  out  8  hours, two BCD digits
- `set_mode`  out  2  current FSM state encoding
- `f_1hr`  out  1  high in the cycle the minute will wrap 59→0 in RUN
- `f_1day`  out  1  high in the cycle the hour will wrap 23→0 in RUN
- `pm`  out  1  present only with `CLK_12HR_EN`
- Clock `clk_1sec` only; reset `reset_n` asynchronous active-low.

## Operation
- State registers: `min_q` (6 b, binary), `hr_q` (5 b, binary), `state`, `mode_d`, `inc_d` (previous button levels).
- Reset: `min_q`=0, `hr_q`=0, `state`=RUN, `mode_d`=`inc_d`=0 → `min_bcd`=8'h00, `hr_bcd`=8'h00, `set_mode`=RUN, `f_1hr`=`f_1day`=0, `pm`=0.
- Edge detect: `mode_rise` = `mode_btn` & ~`mode_d`; likewise `inc_rise`. Held button yields a single event.
- FSM: RUN(2'b00) → SET_HR(2'b01) → SET_MIN(2'b10) → RUN, each on `mode_rise`. 2'b11 unreachable; if entered, next state RUN.
- RUN: on `f_1min`, `min_q` increments; 59 wraps to 0 and increments `hr_q`; hour 23 wraps to 0. `inc_rise` ignored.
- SET_HR: `f_1min` ignored (time frozen); `inc_rise` increments `hr_q` mod 24, no carry.
- SET_MIN: `f_1min` ignored; `inc_rise` increments `min_q` mod 60, no carry into hours.
- `f_1hr` = (state==RUN) & `f_1min` & (`min_q`==59); `f_1day` = `f_1hr` & (`hr_q`==23). Combinational.
- BCD outputs combinational from `min_q`/`hr_q`; values out of range never occur.

## Timing
- Counter update on the `clk_1sec` edge where `f_1min`=1 — same edge on which the seconds counter wraps to 0; zero-cycle lag between seconds and minutes rollover.
- Button event acts on the edge where the rise is sampled; display reflects it after that edge.
- `mode_rise` and `inc_rise` same cycle: mode wins, increment dropped.
- `mode_rise` in RUN with `f_1min`=1: minute increment applied AND state moves to SET_HR on the same edge.
- `mode_rise` in SET_MIN with `f_1min`=1: state returns to RUN; that `f_1min` is ignored.
- Reset mid-operation: all registers clear immediately, independent of clock.

## Configuration
- `CLK_12HR_EN` defined: `pm` port exists, `pm` = (`hr_q` ≥ 12); `hr_bcd` shows 12,01..11 (hr_q 0→8'h12, 13→8'h01). Internal counter and flags unchanged (0–23).
- Undefined: no `pm` port; `hr_bcd` shows 00–23.

## Structure
- Package `clk_pkg`: `typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} set_state_t`; constants `MIN_MAX`=59, `HR_MAX`=23; function `to_bcd(input [6:0]) → [7:0]`.
- Sub-module `edge_det` (level in, registered rise pulse out, async reset to 0), instantiated for `mode_btn` and `inc_btn`.

## Test plan
- Reset with buttons idle → `min_bcd`=00, `hr_bcd`=00, `set_mode`=0, flags 0.
- 60 `f_1min` pulses spaced 60 cycles from reset → `min_bcd`=00, `hr_bcd`=01; `f_1hr` high only in the 60th pulse cycle.
- Preload 23:59 via set mode, return to RUN, pulse `f_1min` → `f_1hr`=`f_1day`=1 that cycle, then 00:00.
- mode rise, 5 inc rises, mode rise, 70 inc rises, mode rise → 05:10, `set_mode`=0; `f_1min` pulses during set leave time unchanged.
- `inc_btn` held 10 cycles in SET_MIN → single increment; mode and inc rise together in SET_HR → SET_MIN, hour unchanged.
- With `CLK_12HR_EN`: hours 0, 12, 13 → `hr_bcd` 12/`pm`=0, 12/`pm`=1, 01/`pm`=1.

Source files
------------

// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared set-mode encoding, time limits and BCD conversion
package clk_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } set_state_t;

  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  // Inputs never exceed 59, so both digits fit in four bits.
  function automatic logic [7:0] to_bcd(input logic [6:0] bin);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(bin / 7'd10);
    ones = 4'(bin % 7'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - rising-edge detector for a debounced, synchronous button level
module edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  // Decoded against the registered copy so the event acts on the edge that samples it.
  assign rise = level & ~level_d;

endmodule

// File: rtl/min_hr_cntr.sv
// rtl/min_hr_cntr.sv - minute/hour counter with set-time FSM; CLK_12HR_EN selects 12-hour display with pm
module min_hr_cntr
  import clk_pkg::*;
(
  input  logic       clk_1sec,
  input  logic       reset_n,
  input  logic       f_1min,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic [1:0] set_mode,
  output logic       f_1hr,
`ifdef CLK_12HR_EN
  output logic       f_1day,
  output logic       pm
`else
  output logic       f_1day
`endif
);

  logic [5:0] min_q;
  logic [4:0] hr_q;
  set_state_t state;
  logic       mode_rise;
  logic       inc_rise;

  edge_det u_mode_det (
    .clk     (clk_1sec),
    .reset_n (reset_n),
    .level   (mode_btn),
    .rise    (mode_rise)
  );

  edge_det u_inc_det (
    .clk     (clk_1sec),
    .reset_n (reset_n),
    .level   (inc_btn),
    .rise    (inc_rise)
  );

  always_ff @(posedge clk_1sec or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= 6'd0;
      hr_q  <= 5'd0;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (f_1min) begin
            if (min_q == MIN_MAX) begin
              min_q <= 6'd0;
              hr_q  <= (hr_q == HR_MAX) ? 5'd0 : hr_q + 5'd1;
            end else begin
              min_q <= min_q + 6'd1;
            end
          end
          if (mode_rise) state <= SET_HR;
        end
        // In the set states a simultaneous mode press wins and the increment is dropped.
        SET_HR: begin
          if (mode_rise) begin
            state <= SET_MIN;
          end else if (inc_rise) begin
            hr_q <= (hr_q == HR_MAX) ? 5'd0 : hr_q + 5'd1;
          end
        end
        SET_MIN: begin
          if (mode_rise) begin
            state <= RUN;
          end else if (inc_rise) begin
            min_q <= (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign set_mode = state;
  assign f_1hr    = (state == RUN) & f_1min & (min_q == MIN_MAX);
  assign f_1day   = f_1hr & (hr_q == HR_MAX);
  assign min_bcd  = to_bcd({1'b0, min_q});

`ifdef CLK_12HR_EN
  logic [4:0] hr_disp;

  always_comb begin
    hr_disp = hr_q;
    if (hr_q == 5'd0) begin
      hr_disp = 5'd12;
    end else if (hr_q > 5'd12) begin
      hr_disp = hr_q - 5'd12;
    end
  end

  assign hr_bcd = to_bcd({2'b00, hr_disp});
  assign pm     = (hr_q >= 5'd12);
`else
  assign hr_bcd = to_bcd({2'b00, hr_q});
`endif

endmodule

// File: tb/tb_min_hr_cntr.sv
// tb/tb_min_hr_cntr.sv - directed self-checking bench for min_hr_cntr
module tb_min_hr_cntr;

  logic       clk_1sec;
  logic       reset_n;
  logic       f_1min;
  logic       mode_btn;
  logic       inc_btn;
  logic [7:0] min_bcd;
  logic [7:0] hr_bcd;
  logic [1:0] set_mode;
  logic       f_1hr;
  logic       f_1day;
`ifdef CLK_12HR_EN
  logic       pm;
`endif

  int vectors;
  int miscompares;

  min_hr_cntr dut (
    .clk_1sec (clk_1sec),
    .reset_n  (reset_n),
    .f_1min   (f_1min),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .min_bcd  (min_bcd),
    .hr_bcd   (hr_bcd),
    .set_mode (set_mode),
    .f_1hr    (f_1hr),
`ifdef CLK_12HR_EN
    .f_1day   (f_1day),
    .pm       (pm)
`else
    .f_1day   (f_1day)
`endif
  );

  initial clk_1sec = 1'b0;
  always #5 clk_1sec = ~clk_1sec;

  function automatic logic [7:0] hr_exp(input int h);
    int d;
`ifdef CLK_12HR_EN
    d = (h == 0) ? 12 : (h > 12) ? h - 12 : h;
`else
    d = h;
`endif
    return 8'((d / 10) * 16 + (d % 10));
  endfunction

  task automatic tick();
    @(posedge clk_1sec);
    #1;
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    tick();
    mode_btn = 1'b0;
    tick();
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      inc_btn = 1'b1;
      tick();
      inc_btn = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; f_1min = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    repeat (2) tick();
    vectors += 5;
    if (min_bcd !== 8'h00) begin miscompares++; $display("FAIL reset_min got %h want 00", min_bcd); end
    if (hr_bcd !== hr_exp(0)) begin miscompares++; $display("FAIL reset_hr got %h want %h", hr_bcd, hr_exp(0)); end
    if (set_mode !== 2'd0) begin miscompares++; $display("FAIL reset_mode got %0d want 0", set_mode); end
    if (f_1hr !== 1'b0) begin miscompares++; $display("FAIL reset_f_1hr got %b want 0", f_1hr); end
    if (f_1day !== 1'b0) begin miscompares++; $display("FAIL reset_f_1day got %b want 0", f_1day); end
`ifdef CLK_12HR_EN
    vectors++;
    if (pm !== 1'b0) begin miscompares++; $display("FAIL reset_pm got %b want 0", pm); end
`endif
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_run_hour();
    for (int p = 1; p <= 60; p++) begin
      f_1min = 1'b1;
      #1;
      vectors += 2;
      if (f_1hr !== 1'(p == 60)) begin miscompares++; $display("FAIL run_f_1hr pulse %0d got %b want %b", p, f_1hr, (p == 60)); end
      if (f_1day !== 1'b0) begin miscompares++; $display("FAIL run_f_1day pulse %0d got %b want 0", p, f_1day); end
      tick();
      f_1min = 1'b0;
      repeat (59) tick();
    end
    vectors += 2;
    if (min_bcd !== 8'h00) begin miscompares++; $display("FAIL hour_min got %h want 00", min_bcd); end
    if (hr_bcd !== hr_exp(1)) begin miscompares++; $display("FAIL hour_hr got %h want %h", hr_bcd, hr_exp(1)); end
  endtask

  task automatic test_day_wrap();
    press_mode();
    vectors++;
    if (set_mode !== 2'd1) begin miscompares++; $display("FAIL wrap_mode_hr got %0d want 1", set_mode); end
    press_inc(22);
    press_mode();
    vectors++;
    if (set_mode !== 2'd2) begin miscompares++; $display("FAIL wrap_mode_min got %0d want 2", set_mode); end
    press_inc(59);
    press_mode();
    vectors += 3;
    if (set_mode !== 2'd0) begin miscompares++; $display("FAIL wrap_mode_run got %0d want 0", set_mode); end
    if (min_bcd !== 8'h59) begin miscompares++; $display("FAIL preload_min got %h want 59", min_bcd); end
    if (hr_bcd !== hr_exp(23)) begin miscompares++; $display("FAIL preload_hr got %h want %h", hr_bcd, hr_exp(23)); end
    f_1min = 1'b1;
    #1;
    vectors += 2;
    if (f_1hr !== 1'b1) begin miscompares++; $display("FAIL wrap_f_1hr got %b want 1", f_1hr); end
    if (f_1day !== 1'b1) begin miscompares++; $display("FAIL wrap_f_1day got %b want 1", f_1day); end
    tick();
    f_1min = 1'b0;
    #1;
    vectors += 3;
    if (min_bcd !== 8'h00) begin miscompares++; $display("FAIL wrap_min got %h want 00", min_bcd); end
    if (hr_bcd !== hr_exp(0)) begin miscompares++; $display("FAIL wrap_hr got %h want %h", hr_bcd, hr_exp(0)); end
    if (f_1day !== 1'b0) begin miscompares++; $display("FAIL wrap_f_1day_clear got %b want 0", f_1day); end
  endtask

  task automatic test_set_time();
    press_mode();
    press_inc(5);
    f_1min = 1'b1;
    tick();
    f_1min = 1'b0;
    tick();
    vectors += 2;
    if (hr_bcd !== hr_exp(5)) begin miscompares++; $display("FAIL set_hr got %h want %h", hr_bcd, hr_exp(5)); end
    if (min_bcd !== 8'h00) begin miscompares++; $display("FAIL set_hr_frozen got %h want 00", min_bcd); end
    press_mode();
    press_inc(70);
    f_1min = 1'b1;
    #1;
    vectors++;
    if (f_1hr !== 1'b0) begin miscompares++; $display("FAIL set_min_f_1hr got %b want 0", f_1hr); end
    tick();
    f_1min = 1'b0;
    tick();
    vectors++;
    if (min_bcd !== 8'h10) begin miscompares++; $display("FAIL set_min got %h want 10", min_bcd); end
    press_mode();
    vectors += 3;
    if (set_mode !== 2'd0) begin miscompares++; $display("FAIL set_done_mode got %0d want 0", set_mode); end
    if (hr_bcd !== hr_exp(5)) begin miscompares++; $display("FAIL set_done_hr got %h want %h", hr_bcd, hr_exp(5)); end
    if (min_bcd !== 8'h10) begin miscompares++; $display("FAIL set_done_min got %h want 10", min_bcd); end
  endtask

  task automatic test_held_and_collide();
    press_mode();
    press_mode();
    inc_btn = 1'b1;
    repeat (10) tick();
    inc_btn = 1'b0;
    tick();
    vectors++;
    if (min_bcd !== 8'h11) begin miscompares++; $display("FAIL held_inc got %h want 11", min_bcd); end
    press_mode();
    press_mode();
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    tick();
    vectors += 2;
    if (set_mode !== 2'd2) begin miscompares++; $display("FAIL collide_mode got %0d want 2", set_mode); end
    if (hr_bcd !== hr_exp(5)) begin miscompares++; $display("FAIL collide_hr got %h want %h", hr_bcd, hr_exp(5)); end
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    tick();
    press_mode();
  endtask

  task automatic test_mode_with_f_1min();
    mode_btn = 1'b1;
    f_1min   = 1'b1;
    tick();
    mode_btn = 1'b0;
    f_1min   = 1'b0;
    tick();
    vectors += 2;
    if (min_bcd !== 8'h12) begin miscompares++; $display("FAIL run_exit_min got %h want 12", min_bcd); end
    if (set_mode !== 2'd1) begin miscompares++; $display("FAIL run_exit_mode got %0d want 1", set_mode); end
    press_mode();
    mode_btn = 1'b1;
    f_1min   = 1'b1;
    tick();
    mode_btn = 1'b0;
    f_1min   = 1'b0;
    tick();
    vectors += 2;
    if (set_mode !== 2'd0) begin miscompares++; $display("FAIL min_exit_mode got %0d want 0", set_mode); end
    if (min_bcd !== 8'h12) begin miscompares++; $display("FAIL min_exit_min got %h want 12", min_bcd); end
  endtask

  task automatic test_async_reset();
    press_mode();
    #2;
    reset_n = 1'b0;
    #1;
    vectors += 3;
    if (min_bcd !== 8'h00) begin miscompares++; $display("FAIL async_min got %h want 00", min_bcd); end
    if (hr_bcd !== hr_exp(0)) begin miscompares++; $display("FAIL async_hr got %h want %h", hr_bcd, hr_exp(0)); end
    if (set_mode !== 2'd0) begin miscompares++; $display("FAIL async_mode got %0d want 0", set_mode); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

`ifdef CLK_12HR_EN
  task automatic test_12hr();
    vectors += 2;
    if (hr_bcd !== 8'h12) begin miscompares++; $display("FAIL h0_bcd got %h want 12", hr_bcd); end
    if (pm !== 1'b0) begin miscompares++; $display("FAIL h0_pm got %b want 0", pm); end
    press_mode();
    press_inc(12);
    vectors += 2;
    if (hr_bcd !== 8'h12) begin miscompares++; $display("FAIL h12_bcd got %h want 12", hr_bcd); end
    if (pm !== 1'b1) begin miscompares++; $display("FAIL h12_pm got %b want 1", pm); end
    press_inc(1);
    vectors += 2;
    if (hr_bcd !== 8'h01) begin miscompares++; $display("FAIL h13_bcd got %h want 01", hr_bcd); end
    if (pm !== 1'b1) begin miscompares++; $display("FAIL h13_pm got %b want 1", pm); end
    press_mode();
    press_mode();
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n  = 1'b0;
    f_1min   = 1'b0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    test_reset();
    test_run_hour();
    test_day_wrap();
    test_set_time();
    test_held_and_collide();
    test_mode_with_f_1min();
    test_async_reset();
`ifdef CLK_12HR_EN
    test_12hr();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
